// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the Game-of-Life engine.
//   life_state_t : generation FSM states (IDLE / EVAL / DONE)
//   NB_W         : neighbour-count width (0..8 fits in 4 bits)
//   GEN_W        : generation counter width
//   next_state() : Conway rule, birth on 3, survival on 2 or 3
package life_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } life_state_t;

  localparam int NB_W  = 4;
  localparam int GEN_W = 16;

  function automatic logic next_state(input logic alive, input logic [NB_W-1:0] n);
    return (n == NB_W'(3)) || (alive && (n == NB_W'(2)));
  endfunction

endpackage

// File: rtl/life_neighbour_count.sv
// life_neighbour_count: combinational live-neighbour count for one cell.
// Ports:
//   i_prev  snapshot board, bit k = (row k/W, col k%W)
//   i_idx   index of the cell being evaluated
//   o_n     number of live neighbours, 0..8
// WRAP=0 treats off-board neighbours as dead; WRAP=1 wraps row/col
// modulo H/W by truncating to the row/col field widths.
module life_neighbour_count
  import life_pkg::*;
#(
  parameter int BIT_W = 3,
  parameter int BIT_H = 3,
  parameter int WRAP  = 0
) (
  input  logic [(2**(BIT_W+BIT_H))-1:0] i_prev,
  input  logic [BIT_W+BIT_H-1:0]        i_idx,
  output logic [NB_W-1:0]               o_n
);

  localparam int W  = 2**BIT_W;
  localparam int H  = 2**BIT_H;
  localparam int AW = BIT_W + BIT_H;

  logic [BIT_H-1:0] w_row;
  logic [BIT_W-1:0] w_col;

  assign w_row = i_idx[AW-1:BIT_W];
  assign w_col = i_idx[BIT_W-1:0];

  always_comb begin
    int nr;
    int nc;
    logic [BIT_H-1:0] rr;
    logic [BIT_W-1:0] cc;
    logic inside_b;
    o_n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = int'(w_row) + dr;
        nc = int'(w_col) + dc;
        // Truncation maps -1 to the last row/col and H/W to 0 (torus).
        rr = nr[BIT_H-1:0];
        cc = nc[BIT_W-1:0];
        inside_b = (nr >= 0) && (nr < H) && (nc >= 0) && (nc < W);
        if (((dr != 0) || (dc != 0)) && ((WRAP != 0) || inside_b))
          o_n = o_n + NB_W'(i_prev[{rr, cc}]);
      end
    end
  end

endmodule

// File: rtl/life_engine.sv
// life_engine: W x H Game-of-Life generation engine, one cell per clk.
// Ports:
//   clk, reset (sync, active-low)
//   frame_tick, run, step, load : generation triggers / seed reload
//   rd_addr, rd_data            : pixel-side read, always a complete generation
//   busy, gen_count, overrun    : status
//   population                  : live-cell count of the last generation
//                                 (only when LIFE_STATS_EN is defined)
// Optional feature macro: LIFE_STATS_EN.
//
// state  | meaning
// IDLE   | board stable; a trigger snapshots curr into prev
// EVAL   | one cell of curr rewritten per cycle from prev
// DONE   | generation complete, gen_count advances
module life_engine
  import life_pkg::*;
#(
  parameter int BIT_W = 3,
  parameter int BIT_H = 3,
  parameter int WRAP  = 0,
  parameter logic [(2**(BIT_W+BIT_H))-1:0] SEED = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   run,
  input  logic                   step,
  input  logic                   load,
  input  logic [BIT_W+BIT_H-1:0] rd_addr,
  output logic                   rd_data,
  output logic                   busy,
  output logic [GEN_W-1:0]       gen_count,
  output logic                   overrun
`ifdef LIFE_STATS_EN
  ,
  output logic [BIT_W+BIT_H:0]   population
`endif
);

  localparam int AW   = BIT_W + BIT_H;
  localparam int SIZE = 2**AW;

  life_state_t      r_state;
  life_state_t      w_state_nxt;
  logic [SIZE-1:0]  r_curr;
  logic [SIZE-1:0]  r_prev;
  logic [AW-1:0]    r_idx;
  logic [GEN_W-1:0] r_gen;
  logic             r_ovr;
  logic             w_trig;
  logic             w_last;
  logic             w_snap;
  logic             w_new;
  logic [NB_W-1:0]  w_n;

  assign w_trig = (frame_tick & run) | step;
  assign w_last = (r_idx == AW'(SIZE-1));
  assign w_new  = next_state(r_prev[r_idx], w_n);

  life_neighbour_count #(
    .BIT_W(BIT_W),
    .BIT_H(BIT_H),
    .WRAP (WRAP)
  ) u_nb (
    .i_prev(r_prev),
    .i_idx (r_idx),
    .o_n   (w_n)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_trig) w_state_nxt = S_EVAL;
        S_EVAL:  if (w_last) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_snap  = (r_state == S_EVAL) || (r_state == S_DONE);
    busy    = (r_state != S_IDLE);
    // The display reads the snapshot while curr is being rewritten.
    rd_data = w_snap ? r_prev[rd_addr] : r_curr[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_curr <= SEED;
      r_prev <= SEED;
      r_idx  <= '0;
      r_gen  <= '0;
      r_ovr  <= 1'b0;
    end else if (load) begin
      r_curr <= SEED;
      r_prev <= SEED;
      r_idx  <= '0;
    end else begin
      if (w_trig && busy) r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_prev <= r_curr;
            r_idx  <= '0;
          end
        end
        S_EVAL: begin
          r_curr[r_idx] <= w_new;
          // Wraps to 0 after the last cell, ready for the next generation.
          r_idx <= r_idx + 1'b1;
        end
        S_DONE:  r_gen <= r_gen + 1'b1;
        default: ;
      endcase
    end
  end

  assign gen_count = r_gen;
  assign overrun   = r_ovr;

`ifdef LIFE_STATS_EN
  localparam int PW = AW + 1;

  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_pop;

  function automatic logic [PW-1:0] f_popcount(input logic [SIZE-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int k = 0; k < SIZE; k++) c = c + PW'(v[k]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset || load) begin
      r_acc <= '0;
      r_pop <= f_popcount(SEED);
    end else begin
      case (r_state)
        S_IDLE:  if (w_trig) r_acc <= '0;
        S_EVAL:  r_acc <= r_acc + PW'(w_new);
        S_DONE:  r_pop <= r_acc;
        default: ;
      endcase
    end
  end

  assign population = r_pop;
`endif

endmodule

// File: tb/tb_life_engine.sv
module tb_life_engine;

  localparam int N = 5;
  localparam logic [63:0] SD_BLINK  = (64'd1 << 25) | (64'd1 << 26) | (64'd1 << 27);
  localparam logic [63:0] SD_ROW    = 64'h7;
  localparam logic [63:0] SD_GLIDER = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) |
                                      (64'd1 << 17) | (64'd1 << 18);
  localparam logic [63:0] SD_RAND   = 64'h3C5A_96F0_0FE1_7B24;
  localparam logic [63:0] SEEDS [N] = '{SD_BLINK, SD_ROW, SD_ROW, SD_GLIDER, SD_RAND};
  localparam int          WRAPS [N] = '{0, 0, 1, 1, 0};

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        run;
  logic        step;
  logic        load;
  logic [5:0]  rd_addr;
  logic        rd_d   [N];
  logic        busy_d [N];
  logic [15:0] gen_d  [N];
  logic        ovr_d  [N];
`ifdef LIFE_STATS_EN
  logic [6:0]  pop_d  [N];
`endif

  int total;
  int bad;

  logic [63:0] mb  [N];
  logic [63:0] got [N];
  logic [15:0] mgen;
  logic        movr;

  for (genvar g = 0; g < N; g++) begin : g_dut
    life_engine #(
      .BIT_W(3),
      .BIT_H(3),
      .WRAP (WRAPS[g]),
      .SEED (SEEDS[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .frame_tick(frame_tick),
      .run       (run),
      .step      (step),
      .load      (load),
      .rd_addr   (rd_addr),
      .rd_data   (rd_d[g]),
      .busy      (busy_d[g]),
      .gen_count (gen_d[g]),
      .overrun   (ovr_d[g])
`ifdef LIFE_STATS_EN
      ,
      .population(pop_d[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #100 clk = ~clk;

  // Reference: one Conway generation on an 8x8 board from the rules.
  function automatic logic [63:0] model_gen(input logic [63:0] b, input int wrap);
    logic [63:0] nb;
    int cnt;
    int rr;
    int cc;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap != 0) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
              continue;
            end
            if (b[6'(rr * 8 + cc)]) cnt++;
          end
        end
        nb[6'(r * 8 + c)] = (cnt == 3) || (b[6'(r * 8 + c)] && cnt == 2);
      end
    end
    return nb;
  endfunction

  task automatic model_step();
    for (int j = 0; j < N; j++) mb[j] = model_gen(mb[j], WRAPS[j]);
    mgen = mgen + 16'd1;
  endtask

  task automatic model_load();
    for (int j = 0; j < N; j++) mb[j] = SEEDS[j];
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reads all 64 cells of every instance within half a clock, then realigns.
  task automatic read_all();
    @(negedge clk);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #1;
      for (int j = 0; j < N; j++) got[j][6'(a)] = rd_d[j];
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy_d[0] === 1'b1 && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 300) begin
      total++;
      bad++;
      $display("FAIL busy_timeout actual=%0d required=<300", cyc);
    end
  endtask

  task automatic apply(input bit s, input bit t, input bit rv, output int cyc);
    step = s;
    frame_tick = t;
    run = rv;
    @(negedge clk);
    step = 1'b0;
    frame_tick = 1'b0;
    wait_idle(cyc);
  endtask

  task automatic compare_all(input string tag);
    read_all();
    for (int j = 0; j < N; j++) begin
      chk($sformatf("%s_board%0d", tag, j), got[j], mb[j]);
      chk($sformatf("%s_gen%0d", tag, j), 64'(gen_d[j]), 64'(mgen));
      chk($sformatf("%s_ovr%0d", tag, j), 64'(ovr_d[j]), 64'(movr));
      chk($sformatf("%s_busy%0d", tag, j), 64'(busy_d[j]), 64'd0);
    end
  endtask

  typedef struct {
    bit s;
    bit t;
    bit rv;
    int exp_cyc;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    int          cyc;
    logic [63:0] pre [N];
    logic [15:0] g0;
    bit          s;
    bit          t;
    bit          rv;
    bit          trig;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 65};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 65};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 65};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 65};

    total = 0;
    bad = 0;
    step = 1'b0;
    frame_tick = 1'b0;
    run = 1'b0;
    load = 1'b0;
    rd_addr = '0;
    reset = 1'b0;
    mgen = '0;
    movr = 1'b0;
    model_load();

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compare_all("reset");

    // Blinker and edge-mode cases, two run+frame_tick generations.
    apply(1'b0, 1'b1, 1'b1, cyc);
    chk("gen_len", 64'(cyc), 64'd65);
    model_step();
    read_all();
    chk("blink_g1", got[0], (64'd1 << 18) | (64'd1 << 26) | (64'd1 << 34));
    chk("edge_nowrap", got[1], (64'd1 << 1) | (64'd1 << 9));
    chk("edge_wrap", got[2], (64'd1 << 1) | (64'd1 << 9) | (64'd1 << 57));
    apply(1'b0, 1'b1, 1'b1, cyc);
    model_step();
    read_all();
    chk("blink_g2", got[0], SD_BLINK);
    chk("blink_gen", 64'(gen_d[0]), 64'd2);
    compare_all("blink");

    for (int v = 0; v < 6; v++) begin
      apply(vecs[v].s, vecs[v].t, vecs[v].rv, cyc);
      chk($sformatf("vec%0d_cyc", v), 64'(cyc), 64'(vecs[v].exp_cyc));
      if (vecs[v].exp_cyc != 0) model_step();
      compare_all($sformatf("vec%0d", v));
    end

    // load and trigger together: load wins, nothing starts, no overrun.
    run = 1'b0;
    step = 1'b1;
    load = 1'b1;
    @(negedge clk);
    step = 1'b0;
    load = 1'b0;
    chk("loadtrig_busy", 64'(busy_d[0]), 64'd0);
    model_load();
    compare_all("loadtrig");

    // Advance once so the snapshot differs from the seed.
    apply(1'b1, 1'b0, 1'b0, cyc);
    model_step();
    for (int j = 0; j < N; j++) pre[j] = mb[j];
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    read_all();
    for (int j = 0; j < N; j++) chk($sformatf("snap%0d", j), got[j], pre[j]);
    chk("snap_busy", 64'(busy_d[0]), 64'd1);
    wait_idle(cyc);
    model_step();
    compare_all("snap");

    // Extra step at EVAL cycle 10.
    g0 = gen_d[0];
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (9) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("ovr_set", 64'(ovr_d[0]), 64'd1);
    wait_idle(cyc);
    repeat (3) @(negedge clk);
    chk("ovr_busy_after", 64'(busy_d[0]), 64'd0);
    chk("ovr_one_gen", 64'(gen_d[0]), 64'(g0 + 16'd1));
    model_step();
    movr = 1'b1;
    compare_all("ovr");

    // load mid-EVAL.
    g0 = gen_d[0];
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (20) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("loadmid_busy", 64'(busy_d[0]), 64'd0);
    chk("loadmid_gen", 64'(gen_d[0]), 64'(g0));
    model_load();
    compare_all("loadmid");

    // Glider on the torus: 32 generations bring it home.
    g0 = gen_d[3];
    for (int k = 0; k < 32; k++) begin
      apply(1'b1, 1'b0, 1'b0, cyc);
      model_step();
    end
    read_all();
    chk("glider_home", got[3], SD_GLIDER);
    chk("glider_gen", 64'(gen_d[3] - g0), 64'd32);
    compare_all("glider");

`ifdef LIFE_STATS_EN
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    model_load();
    chk("pop_load", 64'(pop_d[0]), 64'd3);
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 1'b0, 1'b0, cyc);
      model_step();
      chk($sformatf("pop_blink%0d", k), 64'(pop_d[0]), 64'd3);
      chk($sformatf("pop_rand%0d", k), 64'(pop_d[4]), 64'($countones(mb[4])));
    end
`endif

    // Randomized trigger/load schedule against the model.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        model_load();
      end
      s = 1'($urandom_range(0, 1));
      t = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      trig = s | (t & rv);
      apply(s, t, rv, cyc);
      chk($sformatf("rnd%0d_cyc", k), 64'(cyc), trig ? 64'd65 : 64'd0);
      if (trig) model_step();
      compare_all($sformatf("rnd%0d", k));
    end

    // Reset mid-EVAL.
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mgen = '0;
    movr = 1'b0;
    model_load();
    compare_all("rstmid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
